// File: rtl/fps_arbiter.sv
// fps_arbiter: two-requester round-robin front end for a shared, non-stalling
// FP add pipeline. It issues operands, tracks the owner of each in-flight
// operation, and routes each result back to its requester as a one-cycle pulse.
module fps_arbiter #(
    parameter int unsigned LAT = 3,
    parameter int unsigned W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_sub,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_sub,
    output logic [W-1:0] fps_a,
    output logic [W-1:0] fps_b,
    input  logic [W-1:0] fps_c,
    output logic         res0_valid,
    output logic [W-1:0] res0_data,
    output logic         res1_valid,
    output logic [W-1:0] res1_data,
    output logic         idle
);

    // Priority pointer: 0 favours requester 0 when both are valid.
    logic         ptr;
    logic         grant0;
    logic         grant1;
    logic [W-1:0] selA;
    logic [W-1:0] selB;
    logic         selSub;
    logic [W-1:0] adjB;

    // Issue stage (aligned with fps_a/fps_b) followed by a LAT-deep chain
    // that tracks the shared pipeline's depth.
    logic           issueVld;
    logic           issueTag;
    logic [LAT-1:0] chainVld;
    logic [LAT-1:0] chainTag;
    logic           res0Q;
    logic           res1Q;

    // Grant selection: single valid requester wins, otherwise the pointer decides.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && en) begin
            if (req0_valid && (!req1_valid || !ptr)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Operand mux for the granted requester, with the subtract sign flip on b.
    always_comb begin
        selA   = req0_a;
        selB   = req0_b;
        selSub = req0_sub;
        if (grant1) begin
            selA   = req1_a;
            selB   = req1_b;
            selSub = req1_sub;
        end
        adjB = {selB[W-1] ^ selSub, selB[W-2:0]};
    end

    // Pointer moves to the requester that lost (or was absent) after each grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (grant0) begin
            ptr <= 1'b1;
        end else if (grant1) begin
            ptr <= 1'b0;
        end
    end

    // Operand registers hold their value until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fps_a <= '0;
            fps_b <= '0;
        end else if (grant0 || grant1) begin
            fps_a <= selA;
            fps_b <= adjB;
        end
    end

    // Owner tracking: shifts every edge since the pipeline never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issueVld <= 1'b0;
            issueTag <= 1'b0;
            chainVld <= '0;
            chainTag <= '0;
        end else begin
            issueVld    <= grant0 || grant1;
            issueTag    <= grant1;
            chainVld[0] <= issueVld;
            chainTag[0] <= issueTag;
            for (int unsigned i = 1; i < LAT; i++) begin
                chainVld[i] <= chainVld[i-1];
                chainTag[i] <= chainTag[i-1];
            end
        end
    end

    // Result pulse registers, steered by the owner tag leaving the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res0Q <= 1'b0;
            res1Q <= 1'b0;
        end else begin
            res0Q <= chainVld[LAT-1] && !chainTag[LAT-1];
            res1Q <= chainVld[LAT-1] &&  chainTag[LAT-1];
        end
    end

    assign res0_valid = res0Q;
    assign res1_valid = res1Q;
    assign res0_data  = fps_c;
    assign res1_data  = fps_c;

    // Idle when nothing is issued, travelling, or being delivered.
    assign idle = !(issueVld || (|chainVld) || res0Q || res1Q);

endmodule

// File: tb/tb_fps_arbiter.sv
// Bench for fps_arbiter: pipeline stub (result = a XOR b), a queue-based
// reference model checked every cycle, and directed scenarios with literal pins.
module tb_fps_arbiter;
    localparam int unsigned LAT = 3;
    localparam int unsigned W   = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_sub, req1_sub;
    logic [W-1:0] fps_a, fps_b, fps_c;
    logic         res0_valid, res1_valid;
    logic [W-1:0] res0_data, res1_data;
    logic         idle;

    int unsigned nChecks = 0;
    int unsigned nFail   = 0;
    int unsigned cyc     = 0;

    fps_arbiter #(.LAT(LAT), .W(W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .fps_a(fps_a), .fps_b(fps_b), .fps_c(fps_c),
        .res0_valid(res0_valid), .res0_data(res0_data),
        .res1_valid(res1_valid), .res1_data(res1_data),
        .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Pipeline stub: captures the issued operands one edge after issue, then LAT more edges.
    logic [W-1:0] pipe [0:LAT];
    always @(posedge clk) begin
        pipe[0] <= fps_a ^ fps_b;
        for (int i = 1; i <= int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign fps_c = pipe[LAT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int unsigned due; logic tag; logic [31:0] data; } exp_t;
    typedef struct { int unsigned edgeNum; logic who; logic [31:0] data; } log_t;

    exp_t mq[$];
    log_t grantLog[$];
    log_t pulseLog[$];
    logic        mPtr = 1'b0;
    logic [31:0] mA = '0;
    logic [31:0] mB = '0;

    // Reference model and per-cycle comparison, sampled mid-cycle.
    always @(negedge clk) begin
        int          winner;
        logic        p0, p1;
        logic [31:0] expData, a, b;
        logic        s;
        if (rst) begin
            mq.delete();
            mPtr = 1'b0;
            mA   = '0;
            mB   = '0;
        end
        winner = -1;
        if (!rst && en) begin
            if (req0_valid && req1_valid) winner = mPtr ? 1 : 0;
            else if (req0_valid)          winner = 0;
            else if (req1_valid)          winner = 1;
        end
        check("ready0", 32'(req0_ready), 32'(winner == 0));
        check("ready1", 32'(req1_ready), 32'(winner == 1));
        check("fps_a", fps_a, mA);
        check("fps_b", fps_b, mB);
        check("idle", 32'(idle), 32'(mq.size() == 0));

        p0 = 1'b0; p1 = 1'b0; expData = '0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            if (mq[0].tag) p1 = 1'b1; else p0 = 1'b1;
            expData = mq[0].data;
            mq.delete(0);
        end
        check("res0_valid", 32'(res0_valid), 32'(p0));
        check("res1_valid", 32'(res1_valid), 32'(p1));
        if (p0) check("res0_data", res0_data, expData);
        if (p1) check("res1_data", res1_data, expData);

        if (req0_ready) grantLog.push_back('{cyc + 1, 1'b0, 32'h0});
        if (req1_ready) grantLog.push_back('{cyc + 1, 1'b1, 32'h0});
        if (res0_valid) pulseLog.push_back('{cyc, 1'b0, res0_data});
        if (res1_valid) pulseLog.push_back('{cyc, 1'b1, res1_data});

        if (winner >= 0) begin
            a = (winner == 0) ? req0_a   : req1_a;
            b = (winner == 0) ? req0_b   : req1_b;
            s = (winner == 0) ? req0_sub : req1_sub;
            if (s) b = b ^ 32'h8000_0000;
            mq.push_back('{cyc + 2 + LAT, (winner == 1), a ^ b});
            mA   = a;
            mB   = b;
            mPtr = (winner == 0);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clearLogs();
        grantLog.delete();
        pulseLog.delete();
    endtask

    initial begin
        logic expOrder [6];
        expOrder = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        rst = 1'b1; en = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_idle", 32'(idle), 32'd1);
        check("reset_fps_a", fps_a, 32'h0);
        check("reset_ready0", 32'(req0_ready), 32'd0);

        // Contention straight out of reset.
        step();
        rst = 1'b0; en = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_a = 32'h1000_0000 + 32'(i); req0_b = 32'h0000_0100 + 32'(i);
            req1_a = 32'h2000_0000 + 32'(i); req1_b = 32'h8000_0200 + 32'(i);
            req1_sub = 1'(i % 2);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (10) step();
        check("contention_grants", grantLog.size(), 32'd6);
        check("contention_pulses", pulseLog.size(), 32'd6);
        for (int k = 0; k < 6 && k < grantLog.size() && k < pulseLog.size(); k++) begin
            check("contention_grant_order", 32'(grantLog[k].who), 32'(expOrder[k]));
            check("contention_pulse_order", 32'(pulseLog[k].who), 32'(expOrder[k]));
            check("contention_latency", pulseLog[k].edgeNum - grantLog[k].edgeNum, 32'd4);
        end
        clearLogs();

        // Single issue from requester 0.
        req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; req0_sub = 1'b0;
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        check("single_fps_b", fps_b, 32'h4000_0000);
        repeat (8) step();
        check("single_pulses", pulseLog.size(), 32'd1);
        if (pulseLog.size() > 0 && grantLog.size() > 0) begin
            check("single_who", 32'(pulseLog[0].who), 32'd0);
            check("single_data", pulseLog[0].data, 32'h7F80_0000);
            check("single_latency", pulseLog[0].edgeNum - grantLog[0].edgeNum, 32'd4);
        end
        clearLogs();

        // Subtract from requester 1.
        req1_valid = 1'b1; req1_a = 32'h3F80_0000; req1_b = 32'h4000_0000; req1_sub = 1'b1;
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        check("sub_fps_b", fps_b, 32'hC000_0000);
        repeat (8) step();
        check("sub_pulses", pulseLog.size(), 32'd1);
        if (pulseLog.size() > 0) begin
            check("sub_who", 32'(pulseLog[0].who), 32'd1);
            check("sub_data", pulseLog[0].data, 32'hFF80_0000);
        end
        clearLogs();

        // Enable gating.
        en = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("en0_ready0", 32'(req0_ready), 32'd0);
            check("en0_ready1", 32'(req1_ready), 32'd0);
            check("en0_idle", 32'(idle), 32'd1);
            step();
        end
        en = 1'b1;
        @(negedge clk);
        check("en1_ready0", 32'(req0_ready), 32'd1);
        check("en1_ready1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (8) step();
        clearLogs();

        // Reset with three operations in flight.
        req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_a = 32'h0F00_0000 + 32'(i); req0_b = 32'h0000_00F0; req0_sub = 1'b0;
            step();
        end
        req0_valid = 1'b0;
        step();
        rst = 1'b1;
        clearLogs();
        @(negedge clk);
        check("midrst_idle", 32'(idle), 32'd1);
        check("midrst_res0", 32'(res0_valid), 32'd0);
        step();
        rst = 1'b0;
        repeat (8) step();
        check("midrst_no_pulses", pulseLog.size(), 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("midrst_ptr_ready0", 32'(req0_ready), 32'd1);
        check("midrst_ptr_ready1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (8) step();
        check("postrst_pulses", pulseLog.size(), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
